// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: operand width, op encodings and the
// queued command payload.
package alu_issue_queue_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
  } alu_cmd_t;

  localparam int unsigned CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry command FIFO with wrapping pointers and an occupancy counter.
module alu_cmd_fifo
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  alu_cmd_t               wdata,
  input  logic                   pop,
  output alu_cmd_t               rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  alu_cmd_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Guard here as well so the FIFO can never overwrite or underflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: the read side is masked by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU commands, issues them one at a time to an external registered
// ALU and holds each result until the consumer takes it.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic [OP_W-1:0]        in_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  output logic                   alu_en,
  input  logic [DATA_W-1:0]      alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level
);

  alu_cmd_t wr_cmd;
  alu_cmd_t head;
  logic     empty;
  logic     full;
  logic     push;
  logic     issue;
  logic     pending;

  always_comb begin
    wr_cmd    = '0;
    wr_cmd.a  = in_a;
    wr_cmd.b  = in_b;
    wr_cmd.op = alu_op_e'(in_op);
  end

  assign in_ready = !full;
  assign push     = in_valid && !full;

  // Issue depends only on registered state and out_ready, never on in_valid.
  assign issue  = !empty && !pending && (!out_valid || out_ready);
  assign alu_en = issue;

  assign alu_a  = empty ? '0 : head.a;
  assign alu_b  = empty ? '0 : head.b;
  assign alu_op = empty ? '0 : OP_W'(head.op);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (issue),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  // pending marks the cycle in which the ALU output is valid for capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      pending <= issue;
      if (pending) begin
        out_data  <= alu_result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: queue-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_alu_issue_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_en;
  logic [31:0] alu_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  level;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] got[$];

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ALU: registers its result on the alu_en edge.
  always @(posedge clk) begin
    if (alu_en) alu_result <= calc(alu_a, alu_b, alu_op);
  end

  // Consumer log of accepted results.
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) got.push_back(out_data);
  end

  // Reference model: a command queue, a one-cycle ALU stage and a result slot.
  cmd_t        mq[$];
  bit          model_ok = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pres = '0;
  bit          m_ov = 1'b0;
  logic [31:0] m_od = '0;
  bit          m_push;
  bit          m_pop;
  cmd_t        m_new;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_pend   = 1'b0;
      m_ov     = 1'b0;
      m_od     = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() > 0) && !m_pend && (!m_ov || out_ready);
      if (m_pend) begin
        m_od = m_pres;
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (m_pop) begin
        m_pres = calc(mq[0].a, mq[0].b, mq[0].op);
        void'(mq.pop_front());
      end
      m_pend = m_pop;
      if (m_push) begin
        m_new.a  = in_a;
        m_new.b  = in_b;
        m_new.op = in_op;
        mq.push_back(m_new);
      end
    end
  end

  bit   e_issue;
  cmd_t e_head;

  always @(negedge clk) begin
    if (model_ok) begin
      e_issue = (mq.size() > 0) && !m_pend && (!m_ov || out_ready);
      e_head  = (mq.size() > 0) ? mq[0] : '0;
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("level", 32'(level), 32'(mq.size()));
      chk("alu_en", 32'(alu_en), 32'(e_issue));
      chk("alu_a", alu_a, e_head.a);
      chk("alu_b", alu_b, e_head.b);
      chk("alu_op", 32'(alu_op), 32'(e_head.op));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", out_data, m_od);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bit accepted = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !accepted; k++) begin
      if (in_ready) accepted = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    if (!accepted) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_got(input int n);
    for (int k = 0; k < 300 && got.size() < n; k++) cycle();
    chk("drain_count", 32'(got.size()), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycle();

    // Single add into an empty queue, plus reset values.
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", out_data, 32'(0));
    out_ready = 1'b1;
    send(32'd5, 32'd7, 2'd0);
    chk("t1_alu_en", 32'(alu_en), 32'(1));
    chk("t1_alu_a", alu_a, 32'd5);
    cycle();
    chk("t1_alu_en_off", 32'(alu_en), 32'(0));
    chk("t1_ov_early", 32'(out_valid), 32'(0));
    cycle();
    chk("t1_ov", 32'(out_valid), 32'(1));
    chk("t1_data", out_data, 32'd12);
    cycle();
    chk("t1_ov_clr", 32'(out_valid), 32'(0));

    // Fill to DEPTH with the consumer stalled; the sixth command is held off.
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(32'(10 * i), 32'(i), 2'd0);
    chk("t2_level_full", 32'(level), 32'(4));
    chk("t2_in_ready", 32'(in_ready), 32'(0));
    chk("t2_held_data", out_data, 32'd11);
    in_a = 32'd60; in_b = 32'd6; in_op = 2'd0; in_valid = 1'b1;
    repeat (3) cycle();
    chk("t2_level_hold", 32'(level), 32'(4));
    out_ready = 1'b1;
    send(32'd60, 32'd6, 2'd0);
    wait_got(6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("t2_order", got[i], 32'(11 * (i + 1)));

    // Mixed ops in order.
    do_reset();
    out_ready = 1'b1;
    send(32'd3, 32'd5, 2'd1);
    send(32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'd2);
    send(32'd1, 32'd2, 2'd3);
    wait_got(3);
    if (got.size() == 3) begin
      chk("t3_sub", got[0], 32'hFFFF_FFFE);
      chk("t3_and", got[1], 32'h00F0_00F0);
      chk("t3_or", got[2], 32'd3);
    end

    // Stalled consumer: no issue, stable output and level.
    do_reset();
    out_ready = 1'b0;
    send(32'd1, 32'd1, 2'd0);
    send(32'd2, 32'd2, 2'd0);
    send(32'd3, 32'd3, 2'd0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_alu_en", 32'(alu_en), 32'(0));
      chk("t4_data", out_data, 32'd2);
      chk("t4_level", 32'(level), 32'(2));
      cycle();
    end
    out_ready = 1'b1;
    wait_got(3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("t4_order", got[i], 32'(2 * (i + 1)));

    // Full queue with pops under pressure; ordering over 12 commands.
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(32'(i + 1), 32'd100, 2'd0);
      end
      begin
        for (int k = 0; k < 100 && level != 3'd4; k++) cycle();
        chk("t5_full", 32'(level), 32'(4));
        chk("t5_in_ready", 32'(in_ready), 32'(0));
        repeat (3) cycle();
        chk("t5_full_hold", 32'(level), 32'(4));
        out_ready = 1'b1;
      end
    join
    wait_got(12);
    for (int i = 0; i < 12 && i < got.size(); i++) chk("t5_order", got[i], 32'(i + 101));

    // Reset while a result is in flight.
    do_reset();
    out_ready = 1'b1;
    send(32'd5, 32'd7, 2'd0);
    chk("t6_alu_en", 32'(alu_en), 32'(1));
    send(32'd9, 32'd9, 2'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_ov", 32'(out_valid), 32'(0));
    chk("t6_level", 32'(level), 32'(0));
    chk("t6_in_ready", 32'(in_ready), 32'(1));
    chk("t6_alu_en_off", 32'(alu_en), 32'(0));
    repeat (4) cycle();
    chk("t6_ov_late", 32'(out_valid), 32'(0));
    chk("t6_nothing_out", 32'(got.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
